// File: rtl/ast_split_mgr_pkg.sv
// Shared asteroid types, table sizing, score constants and the split-manager FSM encoding.
package ast_split_mgr_pkg;

    localparam int unsigned XY_FRACTION     = 7;
    localparam int unsigned A_NUM           = 4;
    localparam int unsigned A_SLOTS_DEFAULT = A_NUM * 4;
    localparam int unsigned POS_W_DEFAULT   = 10 + XY_FRACTION;
    localparam int unsigned VEL_W_DEFAULT   = 8;

    localparam logic [15:0] SCORE_LARGE  = 16'd20;
    localparam logic [15:0] SCORE_MED    = 16'd50;
    localparam logic [15:0] SCORE_SMALL  = 16'd100;
    localparam logic [15:0] SCORE_XLARGE = 16'd0;

    typedef enum logic [1:0] {
        AST_SMALL  = 2'd0,
        AST_MED    = 2'd1,
        AST_LARGE  = 2'd2,
        AST_XLARGE = 2'd3
    } ast_t;

    typedef struct packed {
        logic                              valid;
        ast_t                              kind;
        logic signed [POS_W_DEFAULT-1:0]   x;
        logic signed [POS_W_DEFAULT-1:0]   y;
        logic signed [VEL_W_DEFAULT-1:0]   dx;
        logic signed [VEL_W_DEFAULT-1:0]   dy;
    } ast_slot_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SEARCH,
        ST_WRITE,
        ST_DONE
    } split_state_t;

    function automatic ast_t ast_next_size(input ast_t t);
        case (t)
            AST_LARGE: return AST_MED;
            AST_MED:   return AST_SMALL;
            default:   return t;
        endcase
    endfunction

endpackage

// File: rtl/ast_split_mgr_slot_table.sv
// Asteroid slot storage: one write port, a combinational lookup port, a registered
// renderer read port and the per-slot valid vector.
module ast_slot_table
    import ast_split_mgr_pkg::*;
#(
    parameter int unsigned A_SLOTS = A_SLOTS_DEFAULT,
    parameter int unsigned POS_W   = POS_W_DEFAULT,
    parameter int unsigned VEL_W   = VEL_W_DEFAULT,
    localparam int unsigned IW     = $clog2(A_SLOTS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [IW-1:0]           waddr_i,
    input  logic                    wvalid_i,
    input  ast_t                    wkind_i,
    input  logic signed [POS_W-1:0] wx_i,
    input  logic signed [POS_W-1:0] wy_i,
    input  logic signed [VEL_W-1:0] wdx_i,
    input  logic signed [VEL_W-1:0] wdy_i,
    input  logic [IW-1:0]           lk_idx_i,
    output logic                    lk_valid_o,
    output ast_t                    lk_kind_o,
    output logic signed [POS_W-1:0] lk_x_o,
    output logic signed [POS_W-1:0] lk_y_o,
    output logic signed [VEL_W-1:0] lk_dx_o,
    output logic signed [VEL_W-1:0] lk_dy_o,
    input  logic [IW-1:0]           rd_idx_i,
    output logic                    rd_valid_o,
    output ast_t                    rd_kind_o,
    output logic signed [POS_W-1:0] rd_x_o,
    output logic signed [POS_W-1:0] rd_y_o,
    output logic signed [VEL_W-1:0] rd_dx_o,
    output logic signed [VEL_W-1:0] rd_dy_o,
    output logic [A_SLOTS-1:0]      valid_vec_o
);

    logic [A_SLOTS-1:0]      valid_q;
    ast_t                    kind_q [A_SLOTS];
    logic signed [POS_W-1:0] x_q    [A_SLOTS];
    logic signed [POS_W-1:0] y_q    [A_SLOTS];
    logic signed [VEL_W-1:0] dx_q   [A_SLOTS];
    logic signed [VEL_W-1:0] dy_q   [A_SLOTS];

    logic                    rd_valid_q;
    ast_t                    rd_kind_q;
    logic signed [POS_W-1:0] rd_x_q;
    logic signed [POS_W-1:0] rd_y_q;
    logic signed [VEL_W-1:0] rd_dx_q;
    logic signed [VEL_W-1:0] rd_dy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < A_SLOTS; i++) begin
                kind_q[i] <= AST_SMALL;
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                dx_q[i]   <= '0;
                dy_q[i]   <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_kind_q  <= AST_SMALL;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_dx_q    <= '0;
            rd_dy_q    <= '0;
        end else begin
            // Read samples pre-write contents, so a same-cycle write is not visible.
            rd_valid_q <= valid_q[rd_idx_i];
            rd_kind_q  <= kind_q[rd_idx_i];
            rd_x_q     <= x_q[rd_idx_i];
            rd_y_q     <= y_q[rd_idx_i];
            rd_dx_q    <= dx_q[rd_idx_i];
            rd_dy_q    <= dy_q[rd_idx_i];
            if (we_i) begin
                valid_q[waddr_i] <= wvalid_i;
                kind_q[waddr_i]  <= wkind_i;
                x_q[waddr_i]     <= wx_i;
                y_q[waddr_i]     <= wy_i;
                dx_q[waddr_i]    <= wdx_i;
                dy_q[waddr_i]    <= wdy_i;
            end
        end
    end

    assign lk_valid_o  = valid_q[lk_idx_i];
    assign lk_kind_o   = kind_q[lk_idx_i];
    assign lk_x_o      = x_q[lk_idx_i];
    assign lk_y_o      = y_q[lk_idx_i];
    assign lk_dx_o     = dx_q[lk_idx_i];
    assign lk_dy_o     = dy_q[lk_idx_i];

    assign rd_valid_o  = rd_valid_q;
    assign rd_kind_o   = rd_kind_q;
    assign rd_x_o      = rd_x_q;
    assign rd_y_o      = rd_y_q;
    assign rd_dx_o     = rd_dx_q;
    assign rd_dy_o     = rd_dy_q;
    assign valid_vec_o = valid_q;

endmodule

// File: rtl/ast_split_mgr.sv
// Asteroid slot manager: applies collision hits (split/destroy), spawns LARGE asteroids,
// tracks score and live count, and exposes the table through a registered read port.
module ast_split_mgr
    import ast_split_mgr_pkg::*;
#(
    parameter int unsigned A_SLOTS = A_SLOTS_DEFAULT,
    parameter int unsigned POS_W   = POS_W_DEFAULT,
    parameter int unsigned VEL_W   = VEL_W_DEFAULT,
    localparam int unsigned IW     = $clog2(A_SLOTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hit_valid,
    input  logic [IW-1:0]           hit_idx,
    output logic                    hit_ready,
    output logic                    hit_done,
    input  logic                    spawn_valid,
    input  logic signed [POS_W-1:0] spawn_x,
    input  logic signed [POS_W-1:0] spawn_y,
    input  logic signed [VEL_W-1:0] spawn_dx,
    input  logic signed [VEL_W-1:0] spawn_dy,
    output logic                    spawn_ready,
    output logic                    spawn_fail,
    input  logic [IW-1:0]           rd_idx,
    output logic                    rd_valid,
    output ast_t                    rd_type,
    output logic signed [POS_W-1:0] rd_x,
    output logic signed [POS_W-1:0] rd_y,
    output logic signed [VEL_W-1:0] rd_dx,
    output logic signed [VEL_W-1:0] rd_dy,
    output logic [15:0]             score_add,
    output logic [IW:0]             ast_count,
    output logic                    all_clear
);

    localparam logic [IW-1:0] LAST_SLOT = IW'(A_SLOTS - 1);

    split_state_t            state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d, scan_q, scan_d, child_q, child_d;
    logic                    found_q, found_d, is_hit_q, is_hit_d;
    ast_t                    kind_q, kind_d;
    logic signed [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic signed [VEL_W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [15:0]             score_q, score_d;
    logic [IW:0]             count_q, count_d;

    logic                    we, wvalid;
    logic [IW-1:0]           waddr;
    ast_t                    wkind, lk_kind;
    logic signed [POS_W-1:0] wx, wy, lk_x, lk_y;
    logic signed [VEL_W-1:0] wdx, wdy, lk_dx, lk_dy;
    logic                    lk_valid;
    logic [A_SLOTS-1:0]      valid_vec;

    function automatic logic signed [VEL_W-1:0] neg_sat(input logic signed [VEL_W-1:0] v);
        logic signed [VEL_W-1:0] most_neg;
        most_neg = {1'b1, {(VEL_W-1){1'b0}}};
        return (v == most_neg) ? ~most_neg : -v;
    endfunction

    ast_slot_table #(.A_SLOTS(A_SLOTS), .POS_W(POS_W), .VEL_W(VEL_W)) u_table (
        .clk_i(clk),         .rst_i(reset),
        .we_i(we),           .waddr_i(waddr),     .wvalid_i(wvalid),   .wkind_i(wkind),
        .wx_i(wx),           .wy_i(wy),           .wdx_i(wdx),         .wdy_i(wdy),
        .lk_idx_i(idx_q),    .lk_valid_o(lk_valid), .lk_kind_o(lk_kind),
        .lk_x_o(lk_x),       .lk_y_o(lk_y),       .lk_dx_o(lk_dx),     .lk_dy_o(lk_dy),
        .rd_idx_i(rd_idx),   .rd_valid_o(rd_valid), .rd_kind_o(rd_type),
        .rd_x_o(rd_x),       .rd_y_o(rd_y),       .rd_dx_o(rd_dx),     .rd_dy_o(rd_dy),
        .valid_vec_o(valid_vec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            scan_q   <= '0;
            child_q  <= '0;
            found_q  <= 1'b0;
            is_hit_q <= 1'b0;
            kind_q   <= AST_SMALL;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            score_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            scan_q   <= scan_d;
            child_q  <= child_d;
            found_q  <= found_d;
            is_hit_q <= is_hit_d;
            kind_q   <= kind_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            score_q  <= score_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scan_d      = scan_q;
        child_d     = child_q;
        found_d     = found_q;
        is_hit_d    = is_hit_q;
        kind_d      = kind_q;
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        score_d     = score_q;
        count_d     = count_q;
        we          = 1'b0;
        waddr       = idx_q;
        wvalid      = lk_valid;
        wkind       = lk_kind;
        wx          = lk_x;
        wy          = lk_y;
        wdx         = lk_dx;
        wdy         = lk_dy;
        hit_ready   = 1'b0;
        spawn_ready = 1'b0;
        hit_done    = 1'b0;
        spawn_fail  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hit_ready   = 1'b1;
                spawn_ready = !hit_valid;
                if (hit_valid) begin
                    idx_d    = hit_idx;
                    is_hit_d = 1'b1;
                    state_d  = ST_LOOKUP;
                end else if (spawn_valid) begin
                    is_hit_d = 1'b0;
                    kind_d   = AST_LARGE;
                    x_d      = spawn_x;
                    y_d      = spawn_y;
                    dx_d     = spawn_dx;
                    dy_d     = spawn_dy;
                    scan_d   = '0;
                    state_d  = ST_SEARCH;
                end
            end
            ST_LOOKUP: begin
                score_d = SCORE_XLARGE;
                state_d = ST_DONE;
                if (lk_valid) begin
                    case (lk_kind)
                        AST_SMALL: begin
                            we      = 1'b1;
                            wvalid  = 1'b0;
                            score_d = SCORE_SMALL;
                            count_d = count_q - 1'b1;
                        end
                        AST_LARGE, AST_MED: begin
                            // Parent is rewritten here so WRITE only needs the port for the child.
                            score_d = (lk_kind == AST_LARGE) ? SCORE_LARGE : SCORE_MED;
                            we      = 1'b1;
                            wkind   = ast_next_size(lk_kind);
                            wdx     = neg_sat(lk_dy);
                            wdy     = lk_dx;
                            kind_d  = ast_next_size(lk_kind);
                            x_d     = lk_x;
                            y_d     = lk_y;
                            dx_d    = lk_dy;
                            dy_d    = neg_sat(lk_dx);
                            scan_d  = '0;
                            state_d = ST_SEARCH;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SEARCH: begin
                if (!valid_vec[scan_q]) begin
                    child_d = scan_q;
                    found_d = 1'b1;
                    state_d = ST_WRITE;
                end else if (scan_q == LAST_SLOT) begin
                    found_d = 1'b0;
                    state_d = ST_WRITE;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (found_q) begin
                    we      = 1'b1;
                    waddr   = child_q;
                    wvalid  = 1'b1;
                    wkind   = kind_q;
                    wx      = x_q;
                    wy      = y_q;
                    wdx     = dx_q;
                    wdy     = dy_q;
                    count_d = count_q + 1'b1;
                end else if (!is_hit_q) begin
                    spawn_fail = 1'b1;
                end
                state_d = is_hit_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                hit_done = is_hit_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign score_add = score_q;
    assign ast_count = count_q;
    assign all_clear = (count_q == '0);

endmodule

// File: tb/tb_ast_split_mgr.sv
// Self-checking bench for ast_split_mgr against a slot-table reference model.
module tb_ast_split_mgr;
    import ast_split_mgr_pkg::*;

    localparam int A_SLOTS = 16;
    localparam int IW      = 4;
    localparam int POS_W   = 17;
    localparam int VEL_W   = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    hit_valid = 1'b0;
    logic [IW-1:0]           hit_idx = '0;
    logic                    hit_ready, hit_done;
    logic                    spawn_valid = 1'b0;
    logic signed [POS_W-1:0] spawn_x = '0, spawn_y = '0;
    logic signed [VEL_W-1:0] spawn_dx = '0, spawn_dy = '0;
    logic                    spawn_ready, spawn_fail;
    logic [IW-1:0]           rd_idx = '0;
    logic                    rd_valid;
    ast_t                    rd_type;
    logic signed [POS_W-1:0] rd_x, rd_y;
    logic signed [VEL_W-1:0] rd_dx, rd_dy;
    logic [15:0]             score_add;
    logic [IW:0]             ast_count;
    logic                    all_clear;

    ast_split_mgr #(.A_SLOTS(A_SLOTS), .POS_W(POS_W), .VEL_W(VEL_W)) dut (
        .clk(clk), .reset(reset),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_ready(hit_ready), .hit_done(hit_done),
        .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .spawn_dx(spawn_dx), .spawn_dy(spawn_dy), .spawn_ready(spawn_ready), .spawn_fail(spawn_fail),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_type(rd_type), .rd_x(rd_x), .rd_y(rd_y),
        .rd_dx(rd_dx), .rd_dy(rd_dy), .score_add(score_add), .ast_count(ast_count),
        .all_clear(all_clear)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    ast_slot_t   m   [A_SLOTS];
    ast_slot_t   obs [A_SLOTS];
    int          mcount;
    logic [15:0] mscore;

    function automatic logic signed [VEL_W-1:0] vneg(input logic signed [VEL_W-1:0] v);
        int n;
        n = -int'(v);
        if (n > (1 << (VEL_W - 1)) - 1) n = (1 << (VEL_W - 1)) - 1;
        return VEL_W'(n);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < A_SLOTS; i++) m[i] = '0;
        mcount = 0;
        mscore = '0;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < A_SLOTS; i++) if (!m[i].valid) return i;
        return -1;
    endfunction

    // Returns the slot written, or -1 when the table is full.
    function automatic int model_spawn(input logic signed [POS_W-1:0] x, input logic signed [POS_W-1:0] y,
                                       input logic signed [VEL_W-1:0] dx, input logic signed [VEL_W-1:0] dy);
        int k;
        k = model_free();
        if (k >= 0) begin
            m[k].valid = 1'b1; m[k].kind = AST_LARGE;
            m[k].x = x; m[k].y = y; m[k].dx = dx; m[k].dy = dy;
            mcount++;
        end
        return k;
    endfunction

    // Applies a hit to the model; returns expected accept-to-hit_done latency.
    function automatic int model_hit(input int idx);
        ast_slot_t p;
        ast_t      nk;
        int        k;
        p = m[idx];
        if (!p.valid || p.kind == AST_XLARGE) begin
            mscore = 16'd0;
            return 2;
        end
        if (p.kind == AST_SMALL) begin
            m[idx].valid = 1'b0;
            mcount--;
            mscore = 16'd100;
            return 2;
        end
        mscore = (p.kind == AST_LARGE) ? 16'd20 : 16'd50;
        nk     = (p.kind == AST_LARGE) ? AST_MED : AST_SMALL;
        m[idx].kind = nk;
        m[idx].dx   = vneg(p.dy);
        m[idx].dy   = p.dx;
        k = model_free();
        if (k < 0) return A_SLOTS + 3;
        m[k].valid = 1'b1; m[k].kind = nk; m[k].x = p.x; m[k].y = p.y;
        m[k].dx = p.dy; m[k].dy = vneg(p.dx);
        mcount++;
        return 4 + k;
    endfunction

    task automatic do_hit(input int idx, output int lat);
        @(negedge clk);
        hit_valid = 1'b1;
        hit_idx   = IW'(idx);
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            hit_valid = 1'b0;
            if (hit_done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_spawn(input logic signed [POS_W-1:0] x, input logic signed [POS_W-1:0] y,
                            input logic signed [VEL_W-1:0] dx, input logic signed [VEL_W-1:0] dy,
                            output int rdy_lat, output int fail_lat);
        @(negedge clk);
        spawn_valid = 1'b1;
        spawn_x = x; spawn_y = y; spawn_dx = dx; spawn_dy = dy;
        @(posedge clk);
        rdy_lat  = -1;
        fail_lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            spawn_valid = 1'b0;
            if (spawn_fail) fail_lat = c;
            if (spawn_ready) begin
                rdy_lat = c;
                break;
            end
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < A_SLOTS; i++) begin
            @(negedge clk);
            rd_idx = IW'(i);
            @(negedge clk);
            obs[i].valid = rd_valid; obs[i].kind = rd_type;
            obs[i].x = rd_x; obs[i].y = rd_y; obs[i].dx = rd_dx; obs[i].dy = rd_dy;
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({hit_ready, spawn_ready, hit_done, spawn_fail, all_clear} !== 5'b11001) begin
            bad++;
            $display("FAIL reset_flags got %b exp 11001", {hit_ready, spawn_ready, hit_done, spawn_fail, all_clear});
        end
        total++;
        if (score_add !== 16'd0 || ast_count !== 5'd0) begin
            bad++;
            $display("FAIL reset_counts got score=%0d count=%0d exp 0 0", score_add, ast_count);
        end
        total++;
        if ({rd_valid, rd_type, rd_x, rd_y, rd_dx, rd_dy} !== '0) begin
            bad++;
            $display("FAIL reset_rd got %h exp 0", {rd_valid, rd_type, rd_x, rd_y, rd_dx, rd_dy});
        end
        read_all();
        for (int i = 0; i < A_SLOTS; i++) begin
            total++;
            if (obs[i].valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_tbl slot %0d got valid=%b exp 0", i, obs[i].valid);
            end
        end
    endtask

    task automatic test_spawn();
        int k, rl, fl;
        k = model_spawn(17'sd12800, 17'sd6400, 8'sd3, -8'sd2);
        do_spawn(17'sd12800, 17'sd6400, 8'sd3, -8'sd2, rl, fl);
        total++;
        if (rl !== 3 + k || fl !== -1) begin
            bad++;
            $display("FAIL spawn_lat got rdy=%0d fail=%0d exp rdy=%0d fail=-1", rl, fl, 3 + k);
        end
        total++;
        if (ast_count !== 5'd1) begin
            bad++;
            $display("FAIL spawn_count got %0d exp 1", ast_count);
        end
        @(negedge clk);
        rd_idx = '0;
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b1 || rd_type !== AST_LARGE || rd_x !== 17'sd12800 || rd_y !== 17'sd6400 ||
            rd_dx !== 8'sd3 || rd_dy !== -8'sd2) begin
            bad++;
            $display("FAIL spawn_rd got v=%b t=%0d x=%0d y=%0d dx=%0d dy=%0d exp 1 2 12800 6400 3 -2",
                     rd_valid, rd_type, rd_x, rd_y, rd_dx, rd_dy);
        end
    endtask

    task automatic test_split();
        int el, lat;
        el = model_hit(0);
        do_hit(0, lat);
        total++;
        if (lat !== 5 || el !== 5) begin
            bad++;
            $display("FAIL split_lat got %0d exp 5", lat);
        end
        total++;
        if (score_add !== 16'd20 || ast_count !== 5'd2) begin
            bad++;
            $display("FAIL split_score got score=%0d count=%0d exp 20 2", score_add, ast_count);
        end
        @(negedge clk);
        total++;
        if (hit_done !== 1'b0) begin
            bad++;
            $display("FAIL split_done_pulse got %b exp 0", hit_done);
        end
        read_all();
        total++;
        if (obs[0].kind !== AST_MED || obs[0].dx !== 8'sd2 || obs[0].dy !== 8'sd3) begin
            bad++;
            $display("FAIL split_parent got t=%0d dx=%0d dy=%0d exp 1 2 3", obs[0].kind, obs[0].dx, obs[0].dy);
        end
        total++;
        if (obs[1].valid !== 1'b1 || obs[1].kind !== AST_MED || obs[1].x !== 17'sd12800 ||
            obs[1].dx !== -8'sd2 || obs[1].dy !== -8'sd3) begin
            bad++;
            $display("FAIL split_child got v=%b t=%0d x=%0d dx=%0d dy=%0d exp 1 1 12800 -2 -3",
                     obs[1].valid, obs[1].kind, obs[1].x, obs[1].dx, obs[1].dy);
        end
    endtask

    task automatic test_small();
        int seq [6] = '{0, 1, 0, 1, 2, 3};
        int el, lat;
        foreach (seq[n]) begin
            el = model_hit(seq[n]);
            do_hit(seq[n], lat);
            total++;
            if (lat !== el || score_add !== mscore || ast_count !== 5'(mcount)) begin
                bad++;
                $display("FAIL small_hit[%0d] got lat=%0d score=%0d count=%0d exp %0d %0d %0d",
                         n, lat, score_add, ast_count, el, mscore, mcount);
            end
        end
        total++;
        if (all_clear !== 1'b1 || score_add !== 16'd100) begin
            bad++;
            $display("FAIL small_clear got clear=%b score=%0d exp 1 100", all_clear, score_add);
        end
    endtask

    task automatic test_invalid();
        int el, lat;
        el = model_hit(5);
        do_hit(5, lat);
        total++;
        if (lat !== el || score_add !== 16'd0 || ast_count !== 5'd0) begin
            bad++;
            $display("FAIL invalid_hit got lat=%0d score=%0d count=%0d exp %0d 0 0", lat, score_add, ast_count, el);
        end
        read_all();
        for (int i = 0; i < A_SLOTS; i++) begin
            total++;
            if (obs[i].valid !== 1'b0) begin
                bad++;
                $display("FAIL invalid_tbl slot %0d got valid=%b exp 0", i, obs[i].valid);
            end
        end
    endtask

    task automatic test_full();
        logic signed [POS_W-1:0] x, y;
        logic signed [VEL_W-1:0] dx, dy;
        int k, rl, fl, el, lat;
        for (int n = 0; n < A_SLOTS; n++) begin
            x = POS_W'($urandom); y = POS_W'($urandom);
            dx = VEL_W'($urandom); dy = VEL_W'($urandom);
            k = model_spawn(x, y, dx, dy);
            do_spawn(x, y, dx, dy, rl, fl);
            total++;
            if (rl !== 3 + k) begin
                bad++;
                $display("FAIL fill_lat[%0d] got %0d exp %0d", n, rl, 3 + k);
            end
        end
        for (int n = 0; n < 2; n++) begin
            el = model_hit(3);
            do_hit(3, lat);
            total++;
            if (lat !== A_SLOTS + 3 || el !== lat || score_add !== mscore || ast_count !== 5'd16) begin
                bad++;
                $display("FAIL full_hit[%0d] got lat=%0d score=%0d count=%0d exp %0d %0d 16",
                         n, lat, score_add, ast_count, A_SLOTS + 3, mscore);
            end
        end
        do_spawn(17'sd1, 17'sd2, 8'sd3, 8'sd4, rl, fl);
        total++;
        if (fl !== A_SLOTS + 1 || rl !== A_SLOTS + 2) begin
            bad++;
            $display("FAIL full_spawn got fail=%0d rdy=%0d exp %0d %0d", fl, rl, A_SLOTS + 1, A_SLOTS + 2);
        end
        read_all();
        for (int i = 0; i < A_SLOTS; i++) begin
            total++;
            if (obs[i] !== m[i]) begin
                bad++;
                $display("FAIL full_tbl slot %0d got %h exp %h", i, obs[i], m[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int el, k, lat, rl;
        el = model_hit(3);
        k  = model_spawn(17'sd500, -17'sd700, -8'sd128, 8'sd9);
        @(negedge clk);
        hit_valid = 1'b1; hit_idx = 4'd3;
        spawn_valid = 1'b1; spawn_x = 17'sd500; spawn_y = -17'sd700; spawn_dx = -8'sd128; spawn_dy = 8'sd9;
        #1;
        total++;
        if (spawn_ready !== 1'b0 || hit_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready got spawn_ready=%b hit_ready=%b exp 0 1", spawn_ready, hit_ready);
        end
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            hit_valid = 1'b0;
            if (hit_done) begin
                lat = c;
                break;
            end
        end
        total++;
        if (lat !== el || score_add !== 16'd100) begin
            bad++;
            $display("FAIL b2b_hit got lat=%0d score=%0d exp %0d 100", lat, score_add, el);
        end
        @(negedge clk);
        total++;
        if (spawn_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_spawn_ready got %b exp 1", spawn_ready);
        end
        @(posedge clk);
        rl = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            spawn_valid = 1'b0;
            if (spawn_ready) begin
                rl = c;
                break;
            end
        end
        total++;
        if (rl !== 3 + k || ast_count !== 5'd16) begin
            bad++;
            $display("FAIL b2b_spawn got rdy=%0d count=%0d exp %0d 16", rl, ast_count, 3 + k);
        end
        read_all();
        for (int i = 0; i < A_SLOTS; i++) begin
            total++;
            if (obs[i] !== m[i]) begin
                bad++;
                $display("FAIL b2b_tbl slot %0d got %h exp %h", i, obs[i], m[i]);
            end
        end
    endtask

    task automatic test_random();
        logic signed [POS_W-1:0] x, y;
        logic signed [VEL_W-1:0] dx, dy;
        int k, rl, fl, el, lat, idx;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                x  = POS_W'($urandom); y = POS_W'($urandom);
                dx = ($urandom_range(0, 3) == 0) ? -8'sd128 : VEL_W'($urandom);
                dy = ($urandom_range(0, 3) == 0) ? -8'sd128 : VEL_W'($urandom);
                k  = model_spawn(x, y, dx, dy);
                do_spawn(x, y, dx, dy, rl, fl);
                total++;
                if (rl !== ((k >= 0) ? 3 + k : A_SLOTS + 2) || fl !== ((k >= 0) ? -1 : A_SLOTS + 1) ||
                    ast_count !== 5'(mcount)) begin
                    bad++;
                    $display("FAIL rand_spawn[%0d] got rdy=%0d fail=%0d count=%0d exp k=%0d count=%0d",
                             n, rl, fl, ast_count, k, mcount);
                end
            end else begin
                idx = $urandom_range(0, A_SLOTS - 1);
                el  = model_hit(idx);
                do_hit(idx, lat);
                total++;
                if (lat !== el || score_add !== mscore || ast_count !== 5'(mcount)) begin
                    bad++;
                    $display("FAIL rand_hit[%0d] got lat=%0d score=%0d count=%0d exp %0d %0d %0d",
                             n, lat, score_add, ast_count, el, mscore, mcount);
                end
            end
        end
        read_all();
        for (int i = 0; i < A_SLOTS; i++) begin
            total++;
            if (obs[i].valid !== m[i].valid || (m[i].valid && obs[i] !== m[i])) begin
                bad++;
                $display("FAIL rand_tbl slot %0d got %h exp %h", i, obs[i], m[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, rl, fl;
        bit seen;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        k = model_spawn(17'sd64, 17'sd64, 8'sd1, 8'sd1);
        do_spawn(17'sd64, 17'sd64, 8'sd1, 8'sd1, rl, fl);
        @(negedge clk);
        hit_valid = 1'b1; hit_idx = IW'(k);
        @(posedge clk);
        @(negedge clk); hit_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (hit_done) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (hit_done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midreset_done got hit_done seen=%b exp 0", seen);
        end
        total++;
        if ({hit_ready, spawn_ready, spawn_fail, all_clear} !== 4'b1101 || ast_count !== 5'd0 || score_add !== 16'd0) begin
            bad++;
            $display("FAIL midreset_outs got flags=%b count=%0d score=%0d exp 1101 0 0",
                     {hit_ready, spawn_ready, spawn_fail, all_clear}, ast_count, score_add);
        end
        read_all();
        for (int i = 0; i < A_SLOTS; i++) begin
            total++;
            if (obs[i].valid !== 1'b0) begin
                bad++;
                $display("FAIL midreset_tbl slot %0d got valid=%b exp 0", i, obs[i].valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_split();
        test_small();
        test_invalid();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ast_split_mgr.md
# ast_split_mgr

Asteroid slot manager: owns the live asteroid table and is the responder to the collision detector's hit requests. A hit on a slot splits LARGE into two MED, MED into two SMALL, and destroys SMALL. It awards score and maintains the count of live asteroids. The game-start logic spawns fresh LARGE asteroids through a second request port, and the renderer reads slots through a registered read port.

## Interface
Parameters:
- A_SLOTS, 16: asteroid table depth (≥ asteroids::A_NUM·4); index width IW = $clog2(A_SLOTS).
- POS_W, 10+XY_FRACTION: signed fixed-point position width (XY_FRACTION=7 subpixel bits).
- VEL_W, 8: signed velocity width, same fractional scaling as position.

Ports (clk rising edge; reset asynchronous, active-high):
- clk  in  1  system clock
- reset  in  1  async active-high reset
- hit_valid  in  1  collision detector presents a hit
- hit_idx  in  IW  slot index that was hit
- hit_ready  out  1  block can accept a request (high only in IDLE)
- hit_done  out  1  one-cycle pulse when a hit has been fully applied
- spawn_valid  in  1  request to create a LARGE asteroid
- spawn_x, spawn_y  in  POS_W  spawn position
- spawn_dx, spawn_dy  in  VEL_W  spawn velocity
- spawn_ready  out  1  high in IDLE when hit_valid is low
- spawn_fail  out  1  one-cycle pulse: no free slot, spawn dropped
- rd_idx  in  IW  renderer slot select
- rd_valid, rd_type, rd_x, rd_y, rd_dx, rd_dy  out  1/ast_t/POS_W/POS_W/VEL_W/VEL_W  slot contents, registered
- score_add  out  16  points awarded by the last hit (held until the next hit_done)
- ast_count  out  IW+1  number of valid slots
- all_clear  out  1  ast_count==0

## Operation
- Slot = {valid, type, x, y, dx, dy}. Score constants: LARGE 20, MED 50, SMALL 100. XLARGE scores 0.
- FSM states: IDLE, LOOKUP, SEARCH, WRITE, DONE.
- IDLE:
  - hit_valid&&hit_ready captures hit_idx → LOOKUP.
  - Otherwise spawn_valid&&spawn_ready captures the spawn fields, sets scan=0 → SEARCH.
  - A hit wins over a simultaneous spawn; the spawn stays pending (spawn_ready is low that cycle).
- LOOKUP (hit only), based on the hit slot:
  - invalid or XLARGE: no change, score_add=0 → DONE.
  - SMALL: clear valid, score_add=100 → DONE.
  - LARGE or MED: score_add = 20 or 50, scan=0 → SEARCH.
- SEARCH: one slot examined per cycle, ascending from 0.
  - First invalid slot → latch child index, → WRITE.
  - scan==A_SLOTS-1 and that slot is valid → WRITE with no child.
- WRITE:
  - Hit: the parent takes the next smaller type and velocity (-dy,dx). The child, if one was found, gets the same x,y, velocity (dy,-dx), the same smaller type, and valid=1. Negation of the most negative velocity saturates to +max.
  - Spawn: child slot = LARGE with the spawn fields. If no slot was found, pulse spawn_fail and make no write.
- DONE:
  - hit_done pulses (hit path only) → IDLE.
  - The spawn path returns from WRITE directly to IDLE.
- ast_count is a running counter: +1 on each child/spawn write, −1 on each SMALL destroy. It never wraps because of slot limits.
- Read port: rd_* = table[rd_idx], registered, 1-cycle latency, available in every state. A read of a slot written in the same cycle returns the old value.

## Timing
- Reset values: all slots invalid; state IDLE; hit_ready=1 and spawn_ready=1 once reset deasserts; hit_done=0; spawn_fail=0; score_add=0; ast_count=0; all_clear=1; rd_*=0.
- Reset asserted mid-operation aborts the operation immediately. The table is cleared and no hit_done is emitted.
- SMALL, XLARGE or invalid hit: accept → hit_done 2 cycles later (LOOKUP, DONE).
- Split hit where the first free slot is k: accept → hit_done 4+k cycles later.
- Split hit with a full table: hit_done A_SLOTS+3 cycles after accept.
- Spawn: accept → write at cycle 2+k; spawn_fail fires A_SLOTS+1 cycles after accept.
- Requests are accepted only when ready; hit_idx and the spawn fields are sampled only in the accept cycle.

## Structure
- Add to the asteroids package:
  - A_SLOTS default
  - score constants
  - packed struct ast_slot_t
  - enum split_state_t
  - function ast_next_size(ast_t)
- One sub-module, ast_slot_table: slot register array, one write port, the registered read port, and a combinational valid-vector output used by SEARCH.

## Test plan
- Reset then spawn (x=100<<7, y=50<<7, dx=3, dy=−2) → slot 0 LARGE, ast_count=1, rd of slot 0 next cycle matches the inputs.
- Hit slot 0 (LARGE) with slot 1 free → slot 0 MED with velocity (2,3), slot 1 MED with velocity (−2,−3), score_add=20, hit_done 5 cycles after accept, ast_count=2.
- Hit a SMALL slot → valid cleared, score_add=100, hit_done 2 cycles after accept, all_clear=1 when it was the last asteroid.
- Fill all 16 slots, then hit a MED → parent becomes SMALL, no child, ast_count stays 16, hit_done at A_SLOTS+3 cycles. A spawn with a full table → spawn_fail pulse, no write.
- Assert hit_valid and spawn_valid in the same cycle → hit processed first, spawn accepted in the IDLE cycle after hit_done. Hit on an invalid slot → no change, score_add=0.
- Assert reset while in SEARCH → all outputs return to their reset values, no hit_done, table empty.
